// File: rtl/d_mem_sized.sv
// Sized data memory: byte/half/word loads and stores with sign/zero extension,
// alignment and range checking, one outstanding request, configurable latency.
module d_mem_sized #(
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          range_err, align_err, req_err;
  logic          accept, do_write;
  logic [31:0]   rword, shifted, load_val, wd;
  logic [3:0]    be;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid, once raised, holds its payload until that edge.
  assign accept   = req_valid & req_ready & ~reset;
  assign do_write = accept & req_write & ~req_err;

  assign idx       = req_addr[AW+1:2];
  assign range_err = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
  assign rword     = mem[idx];
  assign shifted   = rword >> {req_addr[1:0], 3'b000};

  always_comb begin
    align_err = 1'b0;
    case (req_size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = req_addr[0];
      SZ_WORD: align_err = (req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
    req_err = range_err | align_err;
  end

  // Lane selection and extension for loads; store data replicated across lanes.
  always_comb begin
    load_val = rword;
    be       = 4'b0000;
    wd       = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        load_val = req_unsigned ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        be       = 4'b0001 << req_addr[1:0];
        wd       = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        load_val = req_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        be       = req_addr[1] ? 4'b1100 : 4'b0011;
        wd       = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        load_val = rword;
        be       = 4'b1111;
        wd       = req_wdata;
      end
      default: begin
        load_val = 32'd0;
        be       = 4'b0000;
        wd       = req_wdata;
      end
    endcase
  end

  // Array contents survive reset; only the accepted, error-free store writes.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        err_q   <= req_err;
        rdata_q <= (req_write || req_err) ? 32'd0 : load_val;
        cnt     <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (READ_LATENCY <= 1) ? RESP : WAIT;
      WAIT: if (cnt <= 3'd1) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rdata_q;
    rsp_error = err_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_d_mem_sized.sv
// Bench for d_mem_sized: two instances (depth 16 / latency 1, depth 256 / latency 3)
// driven with directed requests; a monitor pops expected responses from queues.
module tb_d_mem_sized;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  rsp_valid, rsp_ready, rsp_error;
  logic [1:0]  req_size [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];
  logic [1:0]  dbg_state [2];

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_n[2], hs_n[2], drop_n[2], acc_cyc[2];
  bit rdy_next[2], pv[2], pr[2], pe[2];
  logic [31:0] prd[2];

  d_mem_sized #(.DEPTH_WORDS(16), .READ_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]), .dbg_state(dbg_state[0])
  );

  d_mem_sized #(.DEPTH_WORDS(256), .READ_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]), .dbg_state(dbg_state[1])
  );

  // Clock and cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic issue(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic e, input logic [31:0] x, input bit push);
    bit got;
    got = 1'b0;
    req_write[d]    = wr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    req_valid[d]    = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready[d] && !reset) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    req_valid[d] = 1'b0;
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: request @%h never accepted", d, addr);
    end else begin
      acc_cyc[d] = cyc;
      acc_n[d]++;
      if (push) begin
        if (d == 0) exp_q0.push_back({e, x});
        else        exp_q1.push_back({e, x});
      end
    end
  endtask

  task automatic st(input int d, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd, input logic e);
    issue(d, 1'b1, sz, 1'b0, a, wd, e, 32'd0, 1'b1);
  endtask

  task automatic ld(input int d, input logic [1:0] sz, input logic u, input logic [31:0] a,
                    input logic e, input logic [31:0] x);
    issue(d, 1'b0, sz, u, a, 32'd0, e, x, 1'b1);
  endtask

  task automatic wait_idle(input int d);
    for (int i = 0; i < 100 && acc_n[d] != hs_n[d] + drop_n[d]; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: pops on every response handshake, plus protocol checks
  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [32:0] e;
        int lat;
        lat = (d == 0) ? LAT0 : LAT1;
        if (rdy_next[d]) begin
          check("req_ready_after_hs", d, 32'(req_ready[d]), 32'd1);
          rdy_next[d] = 1'b0;
        end
        if (acc_n[d] != hs_n[d] + drop_n[d])
          check("req_ready_while_busy", d, 32'(req_ready[d]), 32'd0);
        if (rsp_valid[d] && !pv[d])
          check("latency", d, 32'(cyc - acc_cyc[d] + 1), 32'(lat));
        if (rsp_valid[d] && pv[d] && !pr[d]) begin
          check("rdata_hold", d, rsp_rdata[d], prd[d]);
          check("error_hold", d, 32'(rsp_error[d]), 32'(pe[d]));
        end
        if (rsp_valid[d] && rsp_ready[d]) begin
          if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp dut%0d: rdata %h error %b with nothing expected",
                     d, rsp_rdata[d], rsp_error[d]);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("rsp_rdata", d, rsp_rdata[d], e[31:0]);
            check("rsp_error", d, 32'(rsp_error[d]), 32'(e[32]));
          end
          hs_n[d]++;
          rdy_next[d] = 1'b1;
        end
        pv[d]  = rsp_valid[d];
        pr[d]  = rsp_ready[d];
        prd[d] = rsp_rdata[d];
        pe[d]  = rsp_error[d];
      end
    end
  endtask

  initial begin
    int p;
    reset        = 1'b1;
    req_valid    = 2'b00;
    req_write    = 2'b00;
    req_unsigned = 2'b00;
    rsp_ready    = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_size[d] = SZ_W; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
      acc_n[d] = 0; hs_n[d] = 0; drop_n[d] = 0; acc_cyc[d] = 0;
      rdy_next[d] = 1'b0; pv[d] = 1'b0; pr[d] = 1'b1; pe[d] = 1'b0; prd[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_req_ready", d, 32'(req_ready[d]), 32'd1);
      check("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      check("reset_rsp_rdata", d, rsp_rdata[d], 32'd0);
      check("reset_rsp_error", d, 32'(rsp_error[d]), 32'd0);
      check("reset_state", d, 32'(dbg_state[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    fork
      monitor();
    join_none

    // Depth 16, latency 1
    st(0, SZ_W, 32'h10, 32'hDEADBEEF, 1'b0);
    ld(0, SZ_W, 1'b0, 32'h10, 1'b0, 32'hDEADBEEF);
    st(0, SZ_W, 32'h10, 32'h11223344, 1'b0);
    st(0, SZ_B, 32'h13, 32'hFFFFFFAA, 1'b0);
    ld(0, SZ_W, 1'b0, 32'h10, 1'b0, 32'hAA223344);
    ld(0, SZ_B, 1'b0, 32'h13, 1'b0, 32'hFFFFFFAA);
    p = acc_cyc[0];
    ld(0, SZ_B, 1'b1, 32'h13, 1'b0, 32'h000000AA);
    check("b2b_spacing", 0, 32'(acc_cyc[0] - p), 32'(LAT0 + 1));
    ld(0, SZ_B, 1'b0, 32'h10, 1'b0, 32'h00000044);
    ld(0, SZ_B, 1'b0, 32'h12, 1'b0, 32'h00000022);
    st(0, SZ_W, 32'h14, 32'h12345678, 1'b0);
    st(0, SZ_H, 32'h16, 32'hFFFF8001, 1'b0);
    ld(0, SZ_W, 1'b0, 32'h14, 1'b0, 32'h80015678);
    ld(0, SZ_H, 1'b0, 32'h16, 1'b0, 32'hFFFF8001);
    ld(0, SZ_H, 1'b1, 32'h16, 1'b0, 32'h00008001);
    ld(0, SZ_H, 1'b0, 32'h14, 1'b0, 32'h00005678);
    ld(0, SZ_H, 1'b1, 32'h11, 1'b1, 32'h00000000);
    st(0, SZ_W, 32'h00, 32'h0BADC0DE, 1'b0);
    st(0, SZ_W, 32'h02, 32'hCAFEF00D, 1'b1);
    ld(0, SZ_W, 1'b0, 32'h00, 1'b0, 32'h0BADC0DE);
    ld(0, SZ_W, 1'b0, 32'h40, 1'b1, 32'h00000000);
    st(0, SZ_W, 32'h40, 32'h99999999, 1'b1);
    ld(0, SZ_W, 1'b0, 32'h00, 1'b0, 32'h0BADC0DE);
    ld(0, SZ_X, 1'b0, 32'h10, 1'b1, 32'h00000000);
    st(0, SZ_X, 32'h10, 32'h00000000, 1'b1);
    ld(0, SZ_W, 1'b1, 32'h10, 1'b0, 32'hAA223344);
    st(0, SZ_W, 32'h3C, 32'h0F0F0F0F, 1'b0);
    ld(0, SZ_W, 1'b0, 32'h3C, 1'b0, 32'h0F0F0F0F);
    ld(0, SZ_B, 1'b0, 32'h3F, 1'b0, 32'h0000000F);
    st(0, SZ_W, 32'h20, 32'h00000000, 1'b0);
    st(0, SZ_B, 32'h21, 32'h0000005A, 1'b0);
    ld(0, SZ_W, 1'b0, 32'h20, 1'b0, 32'h00005A00);

    // Reset coinciding with a store request: the store must not happen
    wait_idle(0);
    wait_idle(1);
    reset = 1'b1;
    req_write[0] = 1'b1; req_size[0] = SZ_W; req_addr[0] = 32'h20;
    req_wdata[0] = 32'hFFFFFFFF; req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid[0] = 1'b0;
    ld(0, SZ_W, 1'b0, 32'h20, 1'b0, 32'h00005A00);

    // Depth 256, latency 3
    st(1, SZ_W, 32'h40, 32'h12345678, 1'b0);
    wait_idle(1);
    rsp_ready[1] = 1'b0;
    ld(1, SZ_W, 1'b0, 32'h40, 1'b0, 32'h12345678);
    repeat (7) @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    ld(1, SZ_B, 1'b1, 32'h42, 1'b0, 32'h00000034);
    p = acc_cyc[1];
    ld(1, SZ_H, 1'b0, 32'h42, 1'b0, 32'h00001234);
    check("b2b_spacing", 1, 32'(acc_cyc[1] - p), 32'(LAT1 + 1));
    st(1, SZ_B, 32'h43, 32'h00000080, 1'b0);
    ld(1, SZ_B, 1'b0, 32'h43, 1'b0, 32'hFFFFFF80);
    ld(1, SZ_H, 1'b0, 32'h42, 1'b0, 32'hFFFF8034);
    st(1, SZ_W, 32'h41, 32'h00000001, 1'b1);
    ld(1, SZ_H, 1'b0, 32'h43, 1'b1, 32'h00000000);
    st(1, SZ_X, 32'h00, 32'h00000001, 1'b1);
    st(1, SZ_W, 32'h3FC, 32'h76543210, 1'b0);
    ld(1, SZ_W, 1'b0, 32'h3FC, 1'b0, 32'h76543210);
    ld(1, SZ_W, 1'b0, 32'h400, 1'b1, 32'h00000000);

    // Reset while the store waits for its response
    wait_idle(0);
    wait_idle(1);
    issue(1, 1'b1, SZ_W, 1'b0, 32'h00, 32'h00000005, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drop_n[1]++;
    @(negedge clk);
    check("ready_after_reset", 1, 32'(req_ready[1]), 32'd1);
    check("valid_after_reset", 1, 32'(rsp_valid[1]), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    ld(1, SZ_W, 1'b0, 32'h00, 1'b0, 32'h00000005);
    ld(0, SZ_W, 1'b0, 32'h10, 1'b0, 32'hAA223344);

    for (int i = 0; i < 100 && (exp_q0.size() + exp_q1.size()) > 0; i++) @(posedge clk);
    if ((exp_q0.size() + exp_q1.size()) > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d responses still outstanding", exp_q0.size() + exp_q1.size());
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
